// File: rtl/adc_capture_sequencer_if.sv
// adc_capture_sequencer_if: DMEM second-port write bus between the ADC capture sequencer and soc_ram
// Signals: adc_we_o write enable, adc_addr_o word address, adc_data_o sample data.
// Modports: master drives the bus (sequencer), slave receives it (RAM side).
interface adc_capture_sequencer_if #(parameter int ADDR_W = 13);
  logic              adc_we_o;
  logic [ADDR_W-1:0] adc_addr_o;
  logic [31:0]       adc_data_o;
  modport master (output adc_we_o, adc_addr_o, adc_data_o);
  modport slave  (input  adc_we_o, adc_addr_o, adc_data_o);
endinterface

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer: pre-trigger ring capture of ADC samples into the DMEM ADC write port
// Ports: sys_clk, sys_rst_n (async active-low); adc_sample_in sample bus (ch0 [11:0], ch1 [27:16]);
//   start_i/abort_i/trig_mode_i/trig_ch_i/trig_level_i/ext_trig_i/pre_len_i/total_len_i/decim_i controls;
//   dmem write bus (adc_we_o/adc_addr_o/adc_data_o); busy_o/armed_o/done_o/trig_idx_o status.
module adc_capture_sequencer #(
  parameter int                ADDR_W    = 13,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h800),
  parameter int                RING_AW   = 11
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [31:0]            adc_sample_in,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [1:0]             trig_mode_i,
  input  logic                   trig_ch_i,
  input  logic [11:0]            trig_level_i,
  input  logic                   ext_trig_i,
  input  logic [RING_AW-1:0]     pre_len_i,
  input  logic [RING_AW:0]       total_len_i,
  input  logic [7:0]             decim_i,
  adc_capture_sequencer_if.master dmem,
  output logic                   busy_o,
  output logic                   armed_o,
  output logic                   done_o,
  output logic [RING_AW-1:0]     trig_idx_o
);
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
  localparam logic [RING_AW:0] DEPTH = {1'b1, {RING_AW{1'b0}}};
  state_t state, nxt;
  logic start_q, ext_q, pv, pend, ch_r;
  logic start_edge, abort_now, active, strobe, trig_hit, cross_up, cross_dn;
  logic [1:0] mode_r;
  logic [11:0] level_r, p_r, s_ch;
  logic [7:0] decim_r, dcnt;
  logic [RING_AW-1:0] pre_r, pre_c, idx;
  logic [RING_AW:0] tot_r, tot_c, cnt, post_len;
  // Lengths are clamped once at start; pre never exceeds total-1 so at least the trigger sample is post.
  assign tot_c = total_len_i > DEPTH ? DEPTH : total_len_i;
  assign pre_c = {1'b0, pre_len_i} >= tot_c ? RING_AW'(tot_c - 1'b1) : pre_len_i;
  assign post_len = tot_r - {1'b0, pre_r} - 1'b1;
  assign start_edge = start_i & ~start_q;
  assign abort_now = abort_i & (state != IDLE);
  assign active = (state == PRE) | (state == ARMED) | (state == POST);
  assign strobe = active & (dcnt == '0);
  assign s_ch = ch_r ? adc_sample_in[27:16] : adc_sample_in[11:0];
  // p_r holds the previous stored sample; pv stays low until one sample of this capture is stored.
  assign cross_up = pv & (p_r < level_r) & (s_ch >= level_r);
  assign cross_dn = pv & (p_r >= level_r) & (s_ch < level_r);
  assign trig_hit = (state == ARMED) & strobe &
                    (mode_r[1] ? (mode_r[0] ? pend : cross_dn) : (mode_r[0] ? cross_up : 1'b1));
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (abort_now) nxt = IDLE;
    else
      case (state)
        IDLE, DONE: if (start_edge) nxt = tot_c == '0 ? DONE : pre_c == '0 ? ARMED : PRE;
        PRE:        if (strobe && cnt + 1'b1 == {1'b0, pre_r}) nxt = ARMED;
        ARMED:      if (trig_hit) nxt = post_len == '0 ? DONE : POST;
        POST:       if (strobe && cnt == 1) nxt = DONE;
        default:    nxt = IDLE;
      endcase
  end
  always_comb begin
    busy_o = active;
    armed_o = state == ARMED;
    done_o = state == DONE;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      start_q <= 1'b0;
      ext_q <= 1'b0;
      pv <= 1'b0;
      pend <= 1'b0;
      ch_r <= 1'b0;
      mode_r <= '0;
      level_r <= '0;
      p_r <= '0;
      decim_r <= '0;
      dcnt <= '0;
      pre_r <= '0;
      tot_r <= '0;
      idx <= '0;
      cnt <= '0;
      trig_idx_o <= '0;
      dmem.adc_we_o <= 1'b0;
      dmem.adc_addr_o <= '0;
      dmem.adc_data_o <= '0;
    end else begin
      start_q <= start_i;
      ext_q <= ext_trig_i;
      dmem.adc_we_o <= strobe & ~abort_now;
      if (abort_now) pend <= 1'b0;
      else if (start_edge && (state == IDLE || state == DONE)) begin
        mode_r <= trig_mode_i;
        ch_r <= trig_ch_i;
        level_r <= trig_level_i;
        decim_r <= decim_i;
        pre_r <= pre_c;
        tot_r <= tot_c;
        idx <= '0;
        dcnt <= '0;
        cnt <= '0;
        pv <= 1'b0;
        pend <= 1'b0;
        trig_idx_o <= '0;
      end else begin
        if (strobe) begin
          dmem.adc_data_o <= adc_sample_in;
          dmem.adc_addr_o <= BASE_ADDR + ADDR_W'(idx);
          idx <= idx + 1'b1;
          dcnt <= decim_r;
          p_r <= s_ch;
          pv <= 1'b1;
        end else if (active) dcnt <= dcnt - 1'b1;
        if (trig_hit) begin
          trig_idx_o <= idx;
          cnt <= post_len;
          pend <= 1'b0;
        end else begin
          if (strobe && state == PRE) cnt <= cnt + 1'b1;
          if (strobe && state == POST) cnt <= cnt - 1'b1;
          if (state == ARMED && ext_trig_i && !ext_q) pend <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer: directed and randomized capture runs checked against a strobe-level reference model
module tb_adc_capture_sequencer;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic [31:0] adc_sample_in = '0;
  logic start_i = 1'b0, abort_i = 1'b0, trig_ch_i = 1'b0, ext_trig_i = 1'b0;
  logic [1:0] trig_mode_i = '0;
  logic [11:0] trig_level_i = '0, total_len_i = '0;
  logic [10:0] pre_len_i = '0, trig_idx_o;
  logic [7:0] decim_i = '0;
  logic busy_o, armed_o, done_o;
  int checks = 0, failures = 0;
  logic [31:0] samp [0:4199];
  logic ext_a [0:4199];
  typedef struct packed {logic [15:0] cyc; logic [12:0] addr; logic [31:0] data;} wr_t;
  wr_t got[$], exp_q[$];

  adc_capture_sequencer_if #(.ADDR_W(13)) dmem ();
  adc_capture_sequencer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .adc_sample_in(adc_sample_in),
    .start_i(start_i), .abort_i(abort_i), .trig_mode_i(trig_mode_i), .trig_ch_i(trig_ch_i),
    .trig_level_i(trig_level_i), .ext_trig_i(ext_trig_i), .pre_len_i(pre_len_i),
    .total_len_i(total_len_i), .decim_i(decim_i), .dmem(dmem), .busy_o(busy_o),
    .armed_o(armed_o), .done_o(done_o), .trig_idx_o(trig_idx_o));

  always #5 sys_clk = ~sys_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] chv(input int c, input logic ch);
    return ch ? samp[c][27:16] : samp[c][11:0];
  endfunction

  task automatic fill(input int w);
    for (int c = 0; c <= w + 1; c++) begin
      samp[c] = $urandom;
      ext_a[c] = 1'($urandom);
    end
  endtask

  task automatic set_ext(input int ec, input int w);
    for (int c = 0; c <= w + 1; c++) ext_a[c] = c >= ec;
  endtask

  // Model: strobe n happens in cycle 1+n*(decim+1) after the start edge, its write is visible one cycle later.
  task automatic run(input string name, input int mode, input int ch, input int level, input int pre_in,
                     input int tot_in, input int decim, input int w, input int restart);
    int tot, pre, p, trig, last, ec, a, n_min;
    bit done_e, armed_e;
    tot = tot_in > 2048 ? 2048 : tot_in;
    pre = tot == 0 ? 0 : (pre_in > tot - 1 ? tot - 1 : pre_in);
    p = decim + 1;
    trig = -1;
    last = 1 << 30;
    ec = 0;
    for (int c = 1; c <= w + 1; c++) if (ext_a[c] && !ext_a[c-1] && ec == 0) ec = c;
    a = pre == 0 ? 1 : (pre - 1) * p + 2;
    if (tot > 0)
      for (int n = pre; 1 + n * p <= w && trig < 0; n++) begin
        int c;
        c = 1 + n * p;
        case (mode)
          0: trig = n;
          1: if (n > 0 && chv(c - p, ch[0]) < level && chv(c, ch[0]) >= level) trig = n;
          2: if (n > 0 && chv(c - p, ch[0]) >= level && chv(c, ch[0]) < level) trig = n;
          default: if (ec >= a && c > ec) trig = n;
        endcase
      end
    if (trig >= 0) last = trig + tot - pre - 1;
    exp_q.delete();
    got.delete();
    if (tot > 0)
      for (int n = 0; n <= last && 1 + n * p <= w; n++)
        exp_q.push_back(wr_t'{16'(2 + n * p), 13'h800 + 13'(n % 2048), samp[1 + n * p]});
    done_e = tot == 0 || (trig >= 0 && 1 + last * p <= w);
    armed_e = !done_e && trig < 0 && (pre == 0 || 1 + (pre - 1) * p <= w);
    trig_mode_i = 2'(mode);
    trig_ch_i = ch[0];
    trig_level_i = 12'(level);
    pre_len_i = 11'(pre_in);
    total_len_i = 12'(tot_in);
    decim_i = 8'(decim);
    start_i = 1'b1;
    adc_sample_in = samp[0];
    ext_trig_i = ext_a[0];
    @(posedge sys_clk); #1;
    trig_mode_i = 2'($urandom);
    trig_ch_i = 1'($urandom);
    trig_level_i = 12'($urandom);
    pre_len_i = 11'($urandom);
    total_len_i = 12'($urandom);
    decim_i = 8'($urandom);
    for (int k = 1; k <= w + 1; k++) begin
      start_i = k == restart;
      adc_sample_in = samp[k];
      ext_trig_i = ext_a[k];
      abort_i = k == w + 1;
      @(negedge sys_clk);
      if (dmem.adc_we_o) got.push_back(wr_t'{16'(k), dmem.adc_addr_o, dmem.adc_data_o});
      if (k == w + 1) begin
        chk({name, " done"}, 64'(done_o), 64'(done_e));
        chk({name, " busy"}, 64'(busy_o), 64'(!done_e));
        chk({name, " armed"}, 64'(armed_o), 64'(armed_e));
        chk({name, " trig_idx"}, 64'(trig_idx_o), 64'(trig >= 0 ? trig % 2048 : 0));
      end
      @(posedge sys_clk); #1;
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    @(negedge sys_clk);
    chk({name, " abort we"}, 64'(dmem.adc_we_o), 64'(0));
    chk({name, " abort busy"}, 64'(busy_o), 64'(0));
    chk({name, " abort done"}, 64'(done_o), 64'(0));
    chk({name, " abort armed"}, 64'(armed_o), 64'(0));
    chk({name, " abort trig_idx"}, 64'(trig_idx_o), 64'(trig >= 0 ? trig % 2048 : 0));
    chk({name, " n_writes"}, 64'(got.size()), 64'(exp_q.size()));
    n_min = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int i = 0; i < n_min; i++) chk($sformatf("%s wr%0d", name, i), 64'(got[i]), 64'(exp_q[i]));
    @(posedge sys_clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst we", 64'(dmem.adc_we_o), 64'(0));
    chk("rst addr", 64'(dmem.adc_addr_o), 64'(0));
    chk("rst data", 64'(dmem.adc_data_o), 64'(0));
    chk("rst busy", 64'(busy_o), 64'(0));
    chk("rst armed", 64'(armed_o), 64'(0));
    chk("rst done", 64'(done_o), 64'(0));
    chk("rst trig_idx", 64'(trig_idx_o), 64'(0));
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    fill(8);
    run("imm4", 0, 0, 0, 0, 4, 0, 8, 0);
    fill(14);
    for (int c = 1; c <= 15; c++) samp[c][11:0] = 12'h3FC + 12'(c - 1);
    run("ramp", 1, 0, 'h400, 3, 8, 0, 14, 7);
    fill(12);
    run("decim", 0, 0, 0, 0, 3, 2, 12, 0);
    fill(2071);
    for (int c = 0; c <= 2072; c++) samp[c][27:16] = c < 2061 ? 12'hA00 : 12'h100;
    run("wrap", 2, 1, 'h800, 2040, 2048, 0, 2071, 0);
    fill(8);
    for (int c = 0; c <= 9; c++) samp[c][11:0] = 12'h100;
    run("abort", 1, 0, 'h800, 2, 10, 0, 8, 0);
    fill(3);
    run("tot0", 0, 0, 0, 5, 0, 0, 3, 0);
    fill(10);
    run("clamp", 0, 0, 0, 10, 5, 0, 10, 0);
    fill(20);
    set_ext(9, 20);
    run("ext", 3, 0, 0, 2, 6, 1, 20, 0);
    for (int r = 0; r < 12; r++) begin
      int mode, tot, dec, w;
      mode = $urandom_range(0, 3);
      tot = $urandom_range(0, 40);
      dec = $urandom_range(0, 3);
      w = $urandom_range(3, (tot + 4) * (dec + 1) + 8);
      fill(w);
      if (mode == 3) set_ext($urandom_range(1, w), w);
      run($sformatf("rnd%0d", r), mode, $urandom_range(0, 1), $urandom_range('h200, 'hE00),
          $urandom_range(0, 24), tot, dec, w, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
